// File: rtl/snake_glyph_pkg.sv
// Glyph codes, 20x20 bitmaps and message contents for the on-screen text overlay.
// Bitmaps are a 5x5 master font blown up to the full cell grid at elaboration.
package snake_glyph_pkg;

   localparam int GLYPH_W_DEF = 20;
   localparam int GLYPH_H_DEF = 20;
   localparam int GLYPH_BITS  = GLYPH_W_DEF * GLYPH_H_DEF;
   localparam int GLYPH_IDX_W = $clog2(GLYPH_BITS);
   localparam int FONT_DIM    = 5;
   localparam int FONT_BITS   = FONT_DIM * FONT_DIM;
   localparam int NUM_CODES   = 16;

   typedef enum logic [3:0] {
      SPACE = 4'd0,
      G     = 4'd1,
      A     = 4'd2,
      M     = 4'd3,
      E     = 4'd4,
      O     = 4'd5,
      V     = 4'd6,
      R     = 4'd7,
      P     = 4'd8,
      U     = 4'd9,
      S     = 4'd10,
      Y     = 4'd11,
      W     = 4'd12,
      I     = 4'd13,
      N     = 4'd14
   } glyph_code_e;

   typedef logic [GLYPH_BITS-1:0] glyph_bitmap_t;

   // Master font rows, MSB = leftmost column of the top row.
   localparam logic [FONT_BITS-1:0] FONT_G = 25'b01110_10000_10011_10001_01110;
   localparam logic [FONT_BITS-1:0] FONT_A = 25'b01110_10001_11111_10001_10001;
   localparam logic [FONT_BITS-1:0] FONT_M = 25'b10001_11011_10101_10001_10001;
   localparam logic [FONT_BITS-1:0] FONT_E = 25'b11111_10000_11110_10000_11111;
   localparam logic [FONT_BITS-1:0] FONT_O = 25'b01110_10001_10001_10001_01110;
   localparam logic [FONT_BITS-1:0] FONT_V = 25'b10001_10001_10001_01010_00100;
   localparam logic [FONT_BITS-1:0] FONT_R = 25'b11110_10001_11110_10100_10010;
   localparam logic [FONT_BITS-1:0] FONT_P = 25'b11110_10001_11110_10000_10000;
   localparam logic [FONT_BITS-1:0] FONT_U = 25'b10001_10001_10001_10001_01110;
   localparam logic [FONT_BITS-1:0] FONT_S = 25'b01111_10000_01110_00001_11110;
   localparam logic [FONT_BITS-1:0] FONT_Y = 25'b10001_01010_00100_00100_00100;
   localparam logic [FONT_BITS-1:0] FONT_W = 25'b10001_10001_10101_11011_10001;
   localparam logic [FONT_BITS-1:0] FONT_I = 25'b01110_00100_00100_00100_01110;
   localparam logic [FONT_BITS-1:0] FONT_N = 25'b10001_11001_10101_10011_10001;

   function automatic glyph_bitmap_t expand_glyph(input logic [FONT_BITS-1:0] font);
      glyph_bitmap_t bm;
      int            fr;
      int            fc;
      bm = '0;
      for (int r = 0; r < GLYPH_H_DEF; r++) begin
         for (int c = 0; c < GLYPH_W_DEF; c++) begin
            fr = (r * FONT_DIM) / GLYPH_H_DEF;
            fc = (c * FONT_DIM) / GLYPH_W_DEF;
            bm[GLYPH_IDX_W'(GLYPH_BITS - 1 - (r * GLYPH_W_DEF + c))] =
               font[5'(FONT_BITS - 1 - (fr * FONT_DIM + fc))];
         end
      end
      return bm;
   endfunction

   localparam glyph_bitmap_t BM_SPACE = '0;
   localparam glyph_bitmap_t BM_G = expand_glyph(FONT_G);
   localparam glyph_bitmap_t BM_A = expand_glyph(FONT_A);
   localparam glyph_bitmap_t BM_M = expand_glyph(FONT_M);
   localparam glyph_bitmap_t BM_E = expand_glyph(FONT_E);
   localparam glyph_bitmap_t BM_O = expand_glyph(FONT_O);
   localparam glyph_bitmap_t BM_V = expand_glyph(FONT_V);
   localparam glyph_bitmap_t BM_R = expand_glyph(FONT_R);
   localparam glyph_bitmap_t BM_P = expand_glyph(FONT_P);
   localparam glyph_bitmap_t BM_U = expand_glyph(FONT_U);
   localparam glyph_bitmap_t BM_S = expand_glyph(FONT_S);
   localparam glyph_bitmap_t BM_Y = expand_glyph(FONT_Y);
   localparam glyph_bitmap_t BM_W = expand_glyph(FONT_W);
   localparam glyph_bitmap_t BM_I = expand_glyph(FONT_I);
   localparam glyph_bitmap_t BM_N = expand_glyph(FONT_N);

   // Indexed by glyph_code_e; code 15 is unassigned and draws nothing.
   localparam glyph_bitmap_t GLYPH_BITMAPS [NUM_CODES] = '{
      BM_SPACE, BM_G, BM_A, BM_M, BM_E, BM_O, BM_V, BM_R,
      BM_P, BM_U, BM_S, BM_Y, BM_W, BM_I, BM_N, BM_SPACE
   };

   function automatic glyph_code_e glyph_at(input int msg, input int slot);
      glyph_code_e code;
      code = SPACE;
      case (msg)
         0: case (slot)
               0: code = G;
               1: code = A;
               2: code = M;
               3: code = E;
               5: code = O;
               6: code = V;
               7: code = E;
               8: code = R;
               default: code = SPACE;
            endcase
         1: case (slot)
               0: code = P;
               1: code = A;
               2: code = U;
               3: code = S;
               4: code = E;
               default: code = SPACE;
            endcase
         2: case (slot)
               0: code = Y;
               1: code = O;
               2: code = U;
               4: code = W;
               5: code = I;
               6: code = N;
               default: code = SPACE;
            endcase
         default: code = SPACE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/glyph_text_renderer_if.sv
// Pixel-stream side of the text overlay: raster position and controls in, lit flag out.
interface glyph_text_renderer_if;
   logic       frame_start;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic [1:0] msg_sel;
   logic       blink_en;
   logic       text_on;

   modport master (
      output frame_start, pixel_x, pixel_y, msg_sel, blink_en,
      input  text_on
   );

   modport slave (
      input  frame_start, pixel_x, pixel_y, msg_sel, blink_en,
      output text_on
   );
endinterface

// File: rtl/glyph_rom.sv
// Glyph bitmap store: (code, bit index) in, one registered bitmap bit out.
module glyph_rom
   import snake_glyph_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             i_code,
   input  logic [GLYPH_IDX_W-1:0] i_bit_idx,
   output logic                   o_bit
);

   logic r_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit <= 1'b0;
      end else begin
         r_bit <= GLYPH_BITMAPS[i_code][i_bit_idx];
      end
   end

   assign o_bit = r_bit;

endmodule

// File: rtl/glyph_text_renderer.sv
// Two-stage text overlay: pixel position -> cell address -> registered glyph bit,
// with per-frame message selection and an optional blink gate.
module glyph_text_renderer
   import snake_glyph_pkg::*;
#(
   parameter int GLYPH_W      = GLYPH_W_DEF,
   parameter int GLYPH_H      = GLYPH_H_DEF,
   parameter int MSG_LEN      = 10,
   parameter int MSG_COUNT    = 4,
   parameter int ORIGIN_X     = 120,
   parameter int ORIGIN_Y     = 220,
   parameter int SCALE_LOG2   = 0,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                  clock_25,
   input  logic                  reset_n,
   glyph_text_renderer_if.slave  bus
);

   localparam int CELLS  = GLYPH_W * GLYPH_H;
   localparam int IDX_W  = $clog2(CELLS);
   localparam int COL_W  = $clog2(GLYPH_W);
   localparam int ROW_W  = $clog2(GLYPH_H);
   localparam int SLOT_W = $clog2(MSG_LEN);
   localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [9:0]      OX       = 10'(ORIGIN_X);
   localparam logic [9:0]      OY       = 10'(ORIGIN_Y);
   localparam logic [9:0]      GW       = 10'(GLYPH_W);
   localparam logic [9:0]      GH       = 10'(GLYPH_H);
   localparam logic [9:0]      ML       = 10'(MSG_LEN);
   localparam logic [2:0]      MC       = 3'(MSG_COUNT);
   localparam logic [FC_W-1:0] FC_LAST  = FC_W'(BLINK_FRAMES - 1);

   // Message table, fixed at elaboration.
   logic [3:0] w_msg_table [MSG_COUNT][MSG_LEN];

   genvar gi, gj;
   for (gi = 0; gi < MSG_COUNT; gi++) begin : g_msg
      for (gj = 0; gj < MSG_LEN; gj++) begin : g_slot
         assign w_msg_table[gi][gj] = glyph_at(gi, gj);
      end
   end

   // Frame-rate state
   logic [1:0]      r_msg;
   logic [FC_W-1:0] r_frame_cnt;
   logic            r_visible;

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         r_msg <= 2'd0;
      end else if (bus.frame_start) begin
         r_msg <= bus.msg_sel;
      end
   end

   // Held in its "just enabled" state while blinking is off.
   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_cnt <= '0;
         r_visible   <= 1'b1;
      end else if (!bus.blink_en) begin
         r_frame_cnt <= '0;
         r_visible   <= 1'b1;
      end else if (bus.frame_start) begin
         if (r_frame_cnt == FC_LAST) begin
            r_frame_cnt <= '0;
            r_visible   <= ~r_visible;
         end else begin
            r_frame_cnt <= r_frame_cnt + FC_W'(1);
         end
      end
   end

   // Stage 1: screen position -> slot / column / row
   logic [9:0]       w_dx;
   logic [9:0]       w_dy;
   logic [9:0]       w_rel_x;
   logic [9:0]       w_rel_y;
   logic [9:0]       w_slot;
   logic [COL_W-1:0] w_col;
   logic             w_in_box;

   assign w_dx     = bus.pixel_x - OX;
   assign w_dy     = bus.pixel_y - OY;
   assign w_rel_x  = w_dx >> SCALE_LOG2;
   assign w_rel_y  = w_dy >> SCALE_LOG2;
   assign w_slot   = w_rel_x / GW;
   assign w_col    = COL_W'(w_rel_x % GW);
   assign w_in_box = (bus.pixel_x >= OX) && (bus.pixel_y >= OY) &&
                     (w_slot < ML) && (w_rel_y < GH);

   logic              r_in_box1;
   logic [SLOT_W-1:0] r_slot;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         r_in_box1 <= 1'b0;
         r_slot    <= '0;
         r_col     <= '0;
         r_row     <= '0;
      end else begin
         r_in_box1 <= w_in_box;
         r_slot    <= SLOT_W'(w_slot);
         r_col     <= w_col;
         r_row     <= ROW_W'(w_rel_y);
      end
   end

   // Stage 2: glyph code and bit address feed the ROM, whose output register is this stage.
   logic [IDX_W-1:0] w_lin;
   logic [IDX_W-1:0] w_bit_idx;
   logic [3:0]       w_code;

   assign w_lin = IDX_W'(r_row) * IDX_W'(GLYPH_W) + IDX_W'(r_col);

   always_comb begin
      w_code    = SPACE;
      w_bit_idx = '0;
      if (r_in_box1 && ({1'b0, r_msg} < MC)) begin
         w_code    = w_msg_table[r_msg][r_slot];
         w_bit_idx = IDX_W'(CELLS - 1) - w_lin;
      end
   end

   logic w_rom_bit;

   glyph_rom u_glyph_rom (
      .clk       (clock_25),
      .rst_n     (reset_n),
      .i_code    (w_code),
      .i_bit_idx (GLYPH_IDX_W'(w_bit_idx)),
      .o_bit     (w_rom_bit)
   );

   // Visibility travels with the pixel so a blink toggle never splits one pixel's state.
   logic r_in_box2;
   logic r_vis2;

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         r_in_box2 <= 1'b0;
         r_vis2    <= 1'b1;
      end else begin
         r_in_box2 <= r_in_box1;
         r_vis2    <= r_visible;
      end
   end

   assign bus.text_on = w_rom_bit & r_in_box2 & r_vis2;

endmodule

// File: tb/tb_glyph_text_renderer.sv
// Scoreboarded bench: two renderers (scale 0 and scale 1) share one pixel stream.
module tb_glyph_text_renderer;

   localparam int BF = 30;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   glyph_text_renderer_if bus0 ();
   glyph_text_renderer_if bus1 ();

   glyph_text_renderer #(.SCALE_LOG2(0), .BLINK_FRAMES(BF)) dut (
      .clock_25 (clk),
      .reset_n  (rst_n),
      .bus      (bus0)
   );

   glyph_text_renderer #(.SCALE_LOG2(1), .BLINK_FRAMES(BF)) dut_s1 (
      .clock_25 (clk),
      .reset_n  (rst_n),
      .bus      (bus1)
   );

   typedef struct {
      string tag;
      logic  e0;
      logic  e1;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   logic tb_vld = 1'b0;
   logic vld_d1 = 1'b0;
   logic vld_d2 = 1'b0;

   int   m_msg    = 0;
   int   m_frames = 0;
   int   g_msel   = 0;
   bit   g_ben    = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic string msg_text(input int msg);
      case (msg)
         0:       return "GAME OVER ";
         1:       return "PAUSE     ";
         2:       return "YOU WIN   ";
         default: return "          ";
      endcase
   endfunction

   function automatic string glyph_art(input byte ch);
      case (ch)
         "G": return ".###./#..../#..##/#...#/.###.";
         "A": return ".###./#...#/#####/#...#/#...#";
         "M": return "#...#/##.##/#.#.#/#...#/#...#";
         "E": return "#####/#..../####./#..../#####";
         "O": return ".###./#...#/#...#/#...#/.###.";
         "V": return "#...#/#...#/#...#/.#.#./..#..";
         "R": return "####./#...#/####./#.#../#..#.";
         "P": return "####./#...#/####./#..../#....";
         "U": return "#...#/#...#/#...#/#...#/.###.";
         "S": return ".####/#..../.###./....#/####.";
         "Y": return "#...#/.#.#./..#../..#../..#..";
         "W": return "#...#/#...#/#.#.#/##.##/#...#";
         "I": return ".###./..#../..#../..#../.###.";
         "N": return "#...#/##..#/#.#.#/#..##/#...#";
         default: return "...../...../...../...../.....";
      endcase
   endfunction

   // Reference: origin (120,220), 20x20 cells, 10 slots, each font pixel = 4x4 cells.
   function automatic logic model_pix(input int msg, input bit vis, input int px, input int py,
                                      input int s);
      int    rx, ry, slot, col;
      string txt, art;
      if (px < 120 || py < 220 || !vis) return 1'b0;
      rx   = (px - 120) >> s;
      ry   = (py - 220) >> s;
      slot = rx / 20;
      col  = rx % 20;
      if (slot >= 10 || ry >= 20) return 1'b0;
      txt = msg_text(msg);
      art = glyph_art(txt[slot]);
      return art[(ry / 4) * 6 + col / 4] == "#";
   endfunction

   task automatic drive(input int px, input int py, input bit fs, input bit chk, input string tag);
      bit   vis;
      exp_t e;
      bus0.pixel_x = 10'(px);  bus1.pixel_x = 10'(px);
      bus0.pixel_y = 10'(py);  bus1.pixel_y = 10'(py);
      bus0.frame_start = fs;   bus1.frame_start = fs;
      bus0.msg_sel = 2'(g_msel); bus1.msg_sel = 2'(g_msel);
      bus0.blink_en = g_ben;   bus1.blink_en = g_ben;
      if (!g_ben) m_frames = 0;
      else if (fs) m_frames++;
      if (fs) m_msg = g_msel;
      vis    = ((m_frames / BF) % 2) == 0;
      tb_vld = chk;
      if (chk) begin
         e.tag = tag;
         e.e0  = model_pix(m_msg, vis, px, py, 0);
         e.e1  = model_pix(m_msg, vis, px, py, 1);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input int px, input int py, input string tag);
      drive(px, py, 1'b0, 1'b1, tag);
   endtask

   task automatic frame();
      drive(0, 0, 1'b1, 1'b0, "");
   endtask

   task automatic idle();
      drive(0, 0, 1'b0, 1'b0, "");
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         vld_d1 <= 1'b0;
         vld_d2 <= 1'b0;
      end else begin
         vld_d2 <= vld_d1;
         vld_d1 <= tb_vld;
      end
   end

   always @(negedge clk) begin : mon_chk
      exp_t e;
      if (vld_d2) begin
         if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            $display("txn %s s0=%b/%b s1=%b/%b", e.tag, bus0.text_on, e.e0, bus1.text_on, e.e1);
            check_val({e.tag, "_s0"}, 32'(bus0.text_on), 32'(e.e0));
            check_val({e.tag, "_s1"}, 32'(bus1.text_on), 32'(e.e1));
         end
      end
   end

   initial begin
      bus0.pixel_x = '0; bus0.pixel_y = '0; bus0.frame_start = 1'b0;
      bus0.msg_sel = '0; bus0.blink_en = 1'b0;
      bus1.pixel_x = '0; bus1.pixel_y = '0; bus1.frame_start = 1'b0;
      bus1.msg_sel = '0; bus1.blink_en = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_text_on_s0", 32'(bus0.text_on), 32'd0);
      check_val("rst_text_on_s1", 32'(bus1.text_on), 32'd0);
      rst_n = 1'b1;

      // Fixed points, edges and scale-1 mapping
      g_msel = 0;
      frame();
      pix(120, 220, "g_topleft");
      pix(126, 220, "g_cell06");
      pix(119, 220, "left_of_box");
      pix(320, 220, "slot10");
      pix(130, 240, "row20");
      pix(132, 220, "s1_cell06_a");
      pix(133, 221, "s1_cell06_b");
      pix(339, 239, "last_cell");

      // Mid-frame select change takes effect only at the next frame_start
      g_msel = 1;
      pix(120, 220, "midframe_hold");
      pix(126, 220, "midframe_hold2");
      frame();
      pix(120, 220, "pause_topleft");

      // frame_start sharing a cycle with an in-box pixel
      g_msel = 0;
      drive(120, 220, 1'b1, 1'b1, "fs_same_cycle");

      for (int m = 0; m < 4; m++) begin
         g_msel = m;
         frame();
         for (int k = 0; k < 20; k++) begin
            pix(int'($urandom_range(100, 340)), int'($urandom_range(210, 250)),
                $sformatf("rand_m%0d", m));
         end
      end

      g_msel = 0;
      g_ben  = 1'b1;
      for (int f = 0; f < 90; f++) begin
         frame();
         pix(126, 220, $sformatf("blink_f%0d", f + 1));
      end
      g_ben = 1'b0;
      idle();
      pix(126, 220, "blink_disabled");

      // Asynchronous reset mid-line with a lit pixel on screen
      g_msel = 1;
      frame();
      pix(120, 220, "pre_rst_p");
      drive(120, 220, 1'b0, 1'b0, "");
      drive(120, 220, 1'b0, 1'b0, "");
      #2;
      check_val("pre_rst_lit", 32'(bus0.text_on), 32'd1);
      rst_n = 1'b0;
      m_msg    = 0;
      m_frames = 0;
      #1;
      check_val("rst_immediate_s0", 32'(bus0.text_on), 32'd0);
      check_val("rst_immediate_s1", 32'(bus1.text_on), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("rst_hold", 32'(bus0.text_on), 32'd0);
      sb_q.delete();
      rst_n = 1'b1;
      pix(120, 220, "post_rst_msg0");
      pix(126, 220, "post_rst_lit");

      repeat (4) idle();
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
